// File: rtl/temp_control_mc.sv
// Multi-zone greenhouse temperature controller: one IDLE/COOLDOWN/HEATUP hysteresis
// FSM per channel with a minimum-dwell counter, sharing runtime-programmable thresholds.
module temp_control_mc #(
  parameter int N_CH        = 4,
  parameter int W           = 8,
  parameter int HYST        = 5,
  parameter int MIN_DWELL   = 16,
  parameter int DEF_COOL_TH = 95,
  parameter int DEF_HEAT_TH = 60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [W-1:0]        cfg_cool_th,
  input  logic [W-1:0]        cfg_heat_th,
  output logic                cfg_err,
  input  logic                sample_valid,
  input  logic [N_CH*W-1:0]   temps,
  output logic [N_CH-1:0]     cool_on,
  output logic [N_CH-1:0]     heat_on,
  output logic [2*N_CH-1:0]   state_dbg
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic signed [W:0]  L_HYST      = (W+1)'(HYST);
  localparam logic signed [W:0]  L_MIN_GAP   = (W+1)'(2*HYST + 1);
  localparam logic [DW-1:0]      L_MIN_DWELL = DW'(MIN_DWELL);
  localparam logic [W-1:0]       L_DEF_COOL  = W'(DEF_COOL_TH);
  localparam logic [W-1:0]       L_DEF_HEAT  = W'(DEF_HEAT_TH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COOL = 2'd1,
    S_HEAT = 2'd2
  } state_t;

  logic [W-1:0]      r_cool_th;
  logic [W-1:0]      r_heat_th;
  logic              r_cfg_err;
  state_t            r_state [N_CH];
  logic [DW-1:0]     r_dwell [N_CH];
  logic [N_CH-1:0]   r_cool_on;
  logic [N_CH-1:0]   r_heat_on;

  logic signed [W:0] w_cool_ext;
  logic signed [W:0] w_heat_ext;
  logic signed [W:0] w_stop_cool;
  logic signed [W:0] w_stop_heat;
  logic signed [W:0] w_cfg_diff;
  logic              w_cfg_ok;
  logic signed [W:0] w_temp     [N_CH];
  state_t            w_state_nx [N_CH];
  logic [DW-1:0]     w_dwell_nx [N_CH];

  // Everything is widened by one sign bit so stop points and the config gap never wrap.
  assign w_cool_ext  = {r_cool_th[W-1], r_cool_th};
  assign w_heat_ext  = {r_heat_th[W-1], r_heat_th};
  assign w_stop_cool = w_cool_ext - L_HYST;
  assign w_stop_heat = w_heat_ext + L_HYST;
  assign w_cfg_diff  = {cfg_cool_th[W-1], cfg_cool_th} - {cfg_heat_th[W-1], cfg_heat_th};
  assign w_cfg_ok    = (w_cfg_diff >= L_MIN_GAP);

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_temp[i]     = {temps[i*W + W - 1], temps[i*W +: W]};
      w_state_nx[i] = r_state[i];
      w_dwell_nx[i] = r_dwell[i];
      if (sample_valid) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_temp[i] >= w_cool_ext) begin
              w_state_nx[i] = S_COOL;
              w_dwell_nx[i] = '0;
            end else if (w_temp[i] <= w_heat_ext) begin
              w_state_nx[i] = S_HEAT;
              w_dwell_nx[i] = '0;
            end
          end
          S_COOL: begin
            if (w_temp[i] <= w_stop_cool && r_dwell[i] >= L_MIN_DWELL) begin
              w_state_nx[i] = S_IDLE;
              w_dwell_nx[i] = '0;
            end else if (r_dwell[i] < L_MIN_DWELL) begin
              w_dwell_nx[i] = r_dwell[i] + DW'(1);
            end
          end
          S_HEAT: begin
            if (w_temp[i] >= w_stop_heat && r_dwell[i] >= L_MIN_DWELL) begin
              w_state_nx[i] = S_IDLE;
              w_dwell_nx[i] = '0;
            end else if (r_dwell[i] < L_MIN_DWELL) begin
              w_dwell_nx[i] = r_dwell[i] + DW'(1);
            end
          end
          default: begin
            w_state_nx[i] = S_IDLE;
            w_dwell_nx[i] = '0;
          end
        endcase
      end
    end
  end

  // FSM evaluation uses the thresholds in force this cycle; a new config applies next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cool_th <= L_DEF_COOL;
      r_heat_th <= L_DEF_HEAT;
      r_cfg_err <= 1'b0;
      r_cool_on <= '0;
      r_heat_on <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_dwell[i] <= '0;
      end
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        r_cool_th <= cfg_cool_th;
        r_heat_th <= cfg_heat_th;
      end
      for (int i = 0; i < N_CH; i++) begin
        r_state[i]   <= w_state_nx[i];
        r_dwell[i]   <= w_dwell_nx[i];
        r_cool_on[i] <= (w_state_nx[i] == S_COOL);
        r_heat_on[i] <= (w_state_nx[i] == S_HEAT);
      end
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_dbg[2*i +: 2] = r_state[i];
    end
  end

  assign cfg_err = r_cfg_err;
  assign cool_on = r_cool_on;
  assign heat_on = r_heat_on;

endmodule

// File: tb/tb_temp_control_mc.sv
// Bench for temp_control_mc: directed scenarios plus random stimulus, all outputs
// compared each cycle against a plain-integer behavioural model.
module tb_temp_control_mc;

  localparam int N_CH      = 4;
  localparam int W         = 8;
  localparam int HYST      = 5;
  localparam int MIN_DWELL = 16;
  localparam int EXPW      = 1 + 4*N_CH;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                cfg_we = 1'b0;
  logic [W-1:0]        cfg_cool_th = '0;
  logic [W-1:0]        cfg_heat_th = '0;
  logic                cfg_err;
  logic                sample_valid = 1'b0;
  logic [N_CH*W-1:0]   temps = '0;
  logic [N_CH-1:0]     cool_on;
  logic [N_CH-1:0]     heat_on;
  logic [2*N_CH-1:0]   state_dbg;

  temp_control_mc dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_cool_th  (cfg_cool_th),
    .cfg_heat_th  (cfg_heat_th),
    .cfg_err      (cfg_err),
    .sample_valid (sample_valid),
    .temps        (temps),
    .cool_on      (cool_on),
    .heat_on      (heat_on),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [EXPW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: mode 0=idle 1=cooling 2=heating, samples counted since entry
  int m_mode [N_CH];
  int m_cnt  [N_CH];
  int m_cool = 95;
  int m_heat = 60;
  bit m_err  = 0;

  function automatic logic [EXPW-1:0] model_vec();
    logic [EXPW-1:0] v;
    v = '0;
    v[EXPW-1] = m_err;
    for (int i = 0; i < N_CH; i++) begin
      v[2*N_CH + 2*i +: 2] = 2'(m_mode[i]);
      v[N_CH + i]          = (m_mode[i] == 2);
      v[i]                 = (m_mode[i] == 1);
    end
    return v;
  endfunction

  task automatic model_step(input bit rst_n, input bit valid, input logic [N_CH*W-1:0] t,
                            input bit we, input int cth, input int hth);
    logic signed [W-1:0] ts;
    int tv;
    if (!rst_n) begin
      m_cool = 95;
      m_heat = 60;
      m_err  = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 0;
        m_cnt[i]  = 0;
      end
      return;
    end
    if (valid) begin
      for (int i = 0; i < N_CH; i++) begin
        ts = t[i*W +: W];
        tv = ts;
        if (m_mode[i] == 0) begin
          if (tv >= m_cool) begin m_mode[i] = 1; m_cnt[i] = 0; end
          else if (tv <= m_heat) begin m_mode[i] = 2; m_cnt[i] = 0; end
        end else if (m_mode[i] == 1) begin
          if (tv <= m_cool - HYST && m_cnt[i] >= MIN_DWELL) m_mode[i] = 0;
          else m_cnt[i]++;
        end else begin
          if (tv >= m_heat + HYST && m_cnt[i] >= MIN_DWELL) m_mode[i] = 0;
          else m_cnt[i]++;
        end
      end
    end
    m_err = we && (cth - hth < 2*HYST + 1);
    if (we && !m_err) begin
      m_cool = cth;
      m_heat = hth;
    end
  endtask

  // driver: inputs change just after a falling edge, outputs checked at the next one
  task automatic step(input bit rst_n, input bit valid, input logic [N_CH*W-1:0] t,
                      input bit we = 0, input int cth = 0, input int hth = 0);
    logic [EXPW-1:0] e;
    rst          = rst_n;
    sample_valid = valid;
    temps        = t;
    cfg_we       = we;
    cfg_cool_th  = cth[W-1:0];
    cfg_heat_th  = hth[W-1:0];
    @(posedge clk);
    model_step(rst_n, valid, t, we, cth, hth);
    exp_q.push_back(model_vec());
    @(negedge clk);
    e = exp_q.pop_front();
    chk("cool_on",   32'(cool_on),   32'(e[N_CH-1:0]));
    chk("heat_on",   32'(heat_on),   32'(e[2*N_CH-1:N_CH]));
    chk("state_dbg", 32'(state_dbg), 32'(e[4*N_CH-1:2*N_CH]));
    chk("cfg_err",   32'(cfg_err),   32'(e[EXPW-1]));
  endtask

  function automatic logic [N_CH*W-1:0] fill(input int v);
    logic [N_CH*W-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i*W +: W] = v[W-1:0];
    return r;
  endfunction

  function automatic logic [N_CH*W-1:0] set_ch(input logic [N_CH*W-1:0] b, input int ch, input int v);
    logic [N_CH*W-1:0] r;
    r = b;
    r[ch*W +: W] = v[W-1:0];
    return r;
  endfunction

  function automatic int clip(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int rnd_temp();
    int sel;
    sel = int'($urandom_range(2));
    if (sel == 0) return int'($urandom_range(255)) - 128;
    if (sel == 1) return clip(m_cool + int'($urandom_range(16)) - 8);
    return clip(m_heat + int'($urandom_range(16)) - 8);
  endfunction

  initial begin
    logic [N_CH*W-1:0] tv;
    int h, c;

    // reset defaults
    repeat (3) step(0, 1, fill(70));
    step(1, 1, fill(70));

    // cooldown entry, dwell, exit on 17th sample; 91 never exits
    tv = set_ch(fill(70), 0, 95);
    step(1, 1, tv);
    repeat (17) step(1, 1, set_ch(fill(70), 0, 80));
    step(1, 1, tv);
    repeat (25) step(1, 1, set_ch(fill(70), 0, 91));
    step(1, 1, set_ch(fill(70), 0, 90));

    // heatup boundary on ch2
    step(1, 1, set_ch(fill(70), 2, 61));
    step(1, 1, set_ch(fill(70), 2, 60));
    repeat (20) step(1, 1, set_ch(fill(70), 2, 64));
    step(1, 1, set_ch(fill(70), 2, 65));

    // sample gating with ch1 cooling
    step(1, 1, set_ch(fill(70), 1, 96));
    repeat (40) step(1, 0, fill(50));
    repeat (20) step(1, 1, fill(50));

    // configuration accept / reject
    repeat (2) step(0, 1, fill(70));
    step(1, 1, fill(70), 1, 100, 89);
    step(1, 1, fill(99));
    step(1, 1, fill(99), 1, 70, 65);
    step(1, 1, fill(99));
    step(1, 1, fill(100), 1, 100, 90);
    step(1, 1, fill(95), 1, 100, 88);

    // extremes without wrap, then reset mid-run
    repeat (2) step(0, 1, fill(0));
    step(1, 1, fill(0), 1, 127, -120);
    tv = set_ch(set_ch(fill(0), 0, -128), 1, 127);
    step(1, 1, tv);
    repeat (17) step(1, 1, set_ch(set_ch(fill(0), 0, -116), 1, 123));
    step(1, 1, set_ch(set_ch(fill(0), 0, -115), 1, 122));
    step(1, 1, tv);
    step(1, 1, tv);
    step(0, 1, tv);
    step(1, 0, tv);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      tv = '0;
      for (int i = 0; i < N_CH; i++) tv = set_ch(tv, i, rnd_temp());
      if ($urandom_range(99) < 6) begin
        h = int'($urandom_range(255)) - 128;
        c = clip(h + int'($urandom_range(40)));
        step(($urandom_range(99) >= 2), ($urandom_range(99) < 70), tv, 1, c, h);
      end else begin
        step(($urandom_range(99) >= 2), ($urandom_range(99) < 70), tv);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/temp_control_mc.md
Name: temp_control_mc

Overview:
Multi-channel successor to the single-zone greenhouse temperature controller. It runs one IDLE/COOLDOWN/HEATUP hysteresis state machine per zone, all sharing a runtime-programmable pair of thresholds. Each active state has a minimum-dwell (anti-chatter) counter. The block sits between the sensor-sampling front end and the per-zone heater/fan drivers.

Parameters:
N_CH, 4, number of independent zones/channels
W, 8, signed temperature width (two's complement)
HYST, 5, hysteresis margin subtracted from/added to the thresholds to form stop points
MIN_DWELL, 16, minimum number of accepted samples a channel stays in COOLDOWN/HEATUP before it may leave (>=1)
DEF_COOL_TH, 95, cooldown threshold loaded at reset
DEF_HEAT_TH, 60, heatup threshold loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset: synchronous, active-low
cfg_we  input  1  single-cycle strobe: load cfg_cool_th/cfg_heat_th
cfg_cool_th  input  W  signed requested cooldown threshold
cfg_heat_th  input  W  signed requested heatup threshold
cfg_err  output  1  one-cycle pulse: last cfg_we rejected
sample_valid  input  1  all channel temperatures valid this cycle
temps  input  N_CH*W  packed signed temps, channel i at [i*W +: W]
cool_on  output  N_CH  per-channel cooling drive
heat_on  output  N_CH  per-channel heating drive
state_dbg  output  2*N_CH  per-channel state, 0=IDLE 1=COOLDOWN 2=HEATUP

Behaviour:
- Reset (rst==0 at posedge): cool_th=DEF_COOL_TH, heat_th=DEF_HEAT_TH, all states IDLE, dwell counters 0, cool_on=heat_on=0, cfg_err=0. Reset overrides cfg_we and sample_valid in the same cycle. Reset mid-operation drops all drives on the next edge.
- Stop points: stop_cool=cool_th-HYST, stop_heat=heat_th+HYST.
  - Computed in W+1 signed bits; no wrap.
  - All comparisons are signed at W+1 bits.
- Config acceptance: on cfg_we, accept only if cfg_cool_th - cfg_heat_th >= 2*HYST+1 (computed at W+1 bits).
  - Accepted: both thresholds update on the next edge and are used from the following cycle.
  - Rejected: old values are kept and cfg_err pulses high for exactly 1 cycle.
  - Channel states and dwell counters are not disturbed by any reconfiguration.
- FSM per channel: evaluates only in cycles with sample_valid=1. Otherwise state, counter and outputs hold.
  - IDLE: temp>=cool_th -> COOLDOWN; else temp<=heat_th -> HEATUP; else stay. The cooldown check has priority.
  - COOLDOWN: temp<=stop_cool AND dwell>=MIN_DWELL -> IDLE; else stay.
  - HEATUP: temp>=stop_heat AND dwell>=MIN_DWELL -> IDLE; else stay.
  - No direct COOLDOWN<->HEATUP transition. A channel spends at least one sample in IDLE between them.
  - Illegal state encoding (3) -> IDLE on the next valid sample, with drives off.
- Dwell counter: cleared to 0 on entering any state. Increments by 1 on each sample_valid while in COOLDOWN/HEATUP, and saturates at MIN_DWELL. Width is clog2(MIN_DWELL+1).
  - The sample that causes entry does not count. Earliest exit is the (MIN_DWELL+1)-th sample after entry.
- Outputs are registered: cool_on[i]=(state_i==COOLDOWN), heat_on[i]=(state_i==HEATUP).
  - Latency: the drive asserts/deasserts on the clock edge that samples the triggering sample_valid, and is visible the cycle after.
  - cool_on[i] and heat_on[i] are never both 1.
- Channels are fully independent. Simultaneous transitions on all channels are legal.

Test Plan:
1. Reset defaults: hold rst=0 3 cycles, then temps all 70, sample_valid=1 -> cool_on=heat_on=0, state_dbg=0; cfg_err=0.
2. Cooldown with dwell (MIN_DWELL=16): ch0 temp 95 for 1 sample -> cool_on[0]=1 next cycle. Then temp 80 -> cool_on[0] stays 1 through sample 16 after entry and drops after the 17th sample. At temp 91 (>stop 90) it never drops.
3. Heatup boundary: ch2 temp 61 -> stays IDLE; temp 60 -> heat_on[2]=1. After dwell, temp 64 -> stays on; temp 65 -> heat_on[2]=0.
4. Sample gating: ch1 in COOLDOWN, temps 50, sample_valid=0 for 40 cycles -> state and dwell frozen, cool_on[1] stays 1. No HEATUP entry until IDLE has been passed on valid samples.
5. Config: cfg_we with cool=100/heat=89 -> accepted, a channel at temp 99 stays IDLE. cfg_we with cool=70/heat=65 -> cfg_err=1 for one cycle, thresholds remain 100/89.
6. Negative temps/overflow (W=8): heat_th=-120 via cfg, temp -128 -> HEATUP. Then cool_th=127 at temp 127 -> COOLDOWN on another channel; stop points -115/122 compared without wrap. Mid-run rst=0 -> all drives 0 on the next edge.
